vga_mode_sequencer: RTL and testbench

//  Sequences mode changes for the VGA path: debounces the raw board switches, then applies them to
//  clk_div/vga_display and the source mux without mid-frame glitches. A resolution change blanks

---
 rtl/vga_mode_sequencer.sv | 158 +++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer.sv
// Debounces board resolution/source switches and applies them to the VGA path on frame boundaries.
// Optional watchdog for a dead sync chain: define MODE_SEQ_TIMEOUT_EN.
module vga_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SETTLE_FRAMES   = 2,
  parameter bit          VSYNC_ACTIVE    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES  = 4000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] res_req,
  input  logic [2:0] src_req,
  input  logic       v_sync,
  output logic [1:0] resolution_select,
  output logic [2:0] output_select,
  output logic       blank,
  output logic       busy,
  output logic       mode_applied
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      SF_LAST = 4'(SETTLE_FRAMES - 1);

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DEBOUNCE, WAIT_FRAME, APPLY, SETTLE} state_t;

  state_t            state, state_n;
  logic [4:0]        cand, cand_n, pending, pending_n, cur, cur_n, req;
  logic [DB_W-1:0]   dbcnt, dbcnt_n;
  logic [WD_W-1:0]   wdcnt, wdcnt_n;
  logic [3:0]        sfcnt, sfcnt_n;
  logic              res_change, res_change_n, blank_n;
  logic              vs1, vs2, fs, wd_expire;

  assign req       = {res_req, src_req};
  assign cur       = {resolution_select, output_select};
  assign fs        = (vs1 == VSYNC_ACTIVE) && (vs2 != VSYNC_ACTIVE);
  assign wd_expire = WD_EN && (wdcnt == WD_LAST);

  always_comb begin
    state_n      = state;
    cand_n       = cand;
    dbcnt_n      = dbcnt;
    pending_n    = pending;
    res_change_n = res_change;
    sfcnt_n      = sfcnt;
    wdcnt_n      = '0;
    cur_n        = cur;
    case (state)
      IDLE: begin
        if (req != cur) begin
          cand_n  = req;
          dbcnt_n = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (req != cand) begin
          cand_n  = req;
          dbcnt_n = '0;
        end else if (dbcnt == DB_LAST) begin
          if (cand == cur) begin
            state_n = IDLE;
          end else begin
            pending_n    = cand;
            res_change_n = (cand[4:3] != cur[4:3]);
            state_n      = WAIT_FRAME;
          end
        end else begin
          dbcnt_n = dbcnt + 1'b1;
        end
      end
      WAIT_FRAME: begin
        if (req != pending) begin
          cand_n  = req;
          dbcnt_n = '0;
          state_n = DEBOUNCE;
        end else if (fs || wd_expire) begin
          // cur is loaded on entry to APPLY so the pulse and the new select share a cycle
          cur_n   = pending;
          state_n = APPLY;
        end else if (WD_EN) begin
          wdcnt_n = wdcnt + 1'b1;
        end
      end
      APPLY: begin
        sfcnt_n = '0;
        state_n = res_change ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (req != pending) begin
          cand_n  = req;
          dbcnt_n = '0;
          state_n = DEBOUNCE;
        end else if (fs) begin
          if (sfcnt == SF_LAST) state_n = IDLE;
          else                  sfcnt_n = sfcnt + 1'b1;
        end else if (wd_expire) begin
          state_n = IDLE;
        end else if (WD_EN) begin
          wdcnt_n = wdcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    blank_n = blank;
    case (state_n)
      IDLE:       blank_n = 1'b0;
      WAIT_FRAME: blank_n = res_change_n;
      SETTLE:     blank_n = 1'b1;
      default:    blank_n = blank;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= WAIT_FRAME;
      cand              <= '0;
      pending           <= '0;
      res_change        <= 1'b1;
      dbcnt             <= '0;
      wdcnt             <= '0;
      sfcnt             <= '0;
      vs1               <= ~VSYNC_ACTIVE;
      vs2               <= ~VSYNC_ACTIVE;
      resolution_select <= '0;
      output_select     <= '0;
      blank             <= 1'b1;
      busy              <= 1'b1;
      mode_applied      <= 1'b0;
    end else begin
      state             <= state_n;
      cand              <= cand_n;
      pending           <= pending_n;
      res_change        <= res_change_n;
      dbcnt             <= dbcnt_n;
      wdcnt             <= wdcnt_n;
      sfcnt             <= sfcnt_n;
      vs1               <= v_sync;
      vs2               <= vs1;
      resolution_select <= cur_n[4:3];
      output_select     <= cur_n[2:0];
      blank             <= blank_n;
      busy              <= (state_n != IDLE);
      mode_applied      <= (state_n == APPLY);
    end
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: directed scenarios plus randomized switch activity,
// every output compared each cycle against a behavioural model.
module tb_vga_mode_sequencer;

  localparam int DB = 4;
  localparam int SF = 2;
  localparam int TO = 50;
  localparam int FRAME = 20;
`ifdef MODE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_DEB = 1, PH_WAIT = 2, PH_APPLY = 3, PH_SET = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] res_req = '0;
  logic [2:0] src_req = '0;
  logic       v_sync = 1'b1;
  logic [1:0] resolution_select;
  logic [2:0] output_select;
  logic       blank, busy, mode_applied;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int frame_starts = 0;
  int fcnt = 0;
  bit vs_run = 1'b1;
  bit model_valid = 1'b0;

  // behavioural model state
  int         m_ph, m_age, m_frames, m_wd;
  logic [4:0] m_cur, m_pend, m_cand;
  logic       m_rchg, m_v1, m_v2, m_blank, m_busy, m_pulse;

  vga_mode_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .SETTLE_FRAMES(SF),
    .VSYNC_ACTIVE(1'b0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .res_req(res_req),
    .src_req(src_req),
    .v_sync(v_sync),
    .resolution_select(resolution_select),
    .output_select(output_select),
    .blank(blank),
    .busy(busy),
    .mode_applied(mode_applied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // v_sync: active-low 2-cycle pulse every FRAME cycles while running, held high otherwise
  always @(negedge clk) begin
    if (vs_run) begin
      fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
      v_sync = (fcnt < 2) ? 1'b0 : 1'b1;
      if (fcnt == 0) frame_starts++;
    end else begin
      v_sync = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) pulses = 0;
    else if (mode_applied === 1'b1) pulses++;
  end

  always @(posedge clk) begin : model
    logic       fs_now;
    logic [4:0] req;
    bit         go_apply;
    model_valid = 1'b1;
    if (rst) begin
      m_ph = PH_WAIT; m_cur = '0; m_pend = '0; m_cand = '0; m_rchg = 1'b1;
      m_age = 0; m_frames = 0; m_wd = 0; m_v1 = 1'b1; m_v2 = 1'b1;
      m_blank = 1'b1; m_busy = 1'b1; m_pulse = 1'b0;
    end else begin
      fs_now = (m_v1 == 1'b0) && (m_v2 == 1'b1);
      m_v2 = m_v1;
      m_v1 = v_sync;
      req = {res_req, src_req};
      go_apply = 1'b0;
      m_pulse = 1'b0;
      case (m_ph)
        PH_IDLE:
          if (req != m_cur) begin m_cand = req; m_age = 0; m_ph = PH_DEB; end
        PH_DEB:
          if (req != m_cand) begin
            m_cand = req; m_age = 0;
          end else begin
            m_age++;
            if (m_age == DB) begin
              if (m_cand == m_cur) m_ph = PH_IDLE;
              else begin
                m_pend = m_cand; m_rchg = (m_cand[4:3] != m_cur[4:3]);
                m_ph = PH_WAIT; m_wd = 0;
              end
            end
          end
        PH_WAIT:
          if (req != m_pend) begin
            m_cand = req; m_age = 0; m_ph = PH_DEB;
          end else if (fs_now) begin
            go_apply = 1'b1;
          end else begin
            m_wd++;
            if (TO_EN && m_wd == TO) go_apply = 1'b1;
          end
        PH_APPLY: begin
          m_frames = 0; m_wd = 0;
          m_ph = m_rchg ? PH_SET : PH_IDLE;
        end
        default:
          if (req != m_pend) begin
            m_cand = req; m_age = 0; m_ph = PH_DEB;
          end else if (fs_now) begin
            m_wd = 0; m_frames++;
            if (m_frames == SF) m_ph = PH_IDLE;
          end else begin
            m_wd++;
            if (TO_EN && m_wd == TO) m_ph = PH_IDLE;
          end
      endcase
      if (go_apply) begin m_cur = m_pend; m_ph = PH_APPLY; m_pulse = 1'b1; end
      if (m_ph == PH_IDLE) m_blank = 1'b0;
      else if (m_ph == PH_WAIT) m_blank = m_rchg;
      else if (m_ph == PH_SET) m_blank = 1'b1;
      m_busy = (m_ph != PH_IDLE);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("res_sel", {6'd0, resolution_select}, {6'd0, m_cur[4:3]});
      chk("out_sel", {5'd0, output_select}, {5'd0, m_cur[2:0]});
      chk("blank", {7'd0, blank}, {7'd0, m_blank});
      chk("busy", {7'd0, busy}, {7'd0, m_busy});
      chk("applied", {7'd0, mode_applied}, {7'd0, m_pulse});
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    chk(name, {7'd0, busy}, 8'd0);
  endtask

  initial begin : stim
    int k, p0, f0, cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset release -> one apply, settle, then idle unblanked
    wait_idle(200, "t1_idle");
    repeat (2) @(negedge clk);
    chk("t1_blank", {7'd0, blank}, 8'd0);
    chk("t1_pulses", pulses[7:0], 8'd1);
    chk("t1_res", {6'd0, resolution_select}, 8'd0);

    // 2: source-only change, never blanks
    p0 = pulses; k = 0; cnt = 0;
    src_req = 3'b010;
    while (output_select !== 3'b010 && k < 100) begin
      @(negedge clk); k++;
      if (blank !== 1'b0) cnt++;
    end
    chk("t2_out", {5'd0, output_select}, 8'h02);
    chk("t2_latency_ok", {7'd0, (k >= 6 && k <= 27)}, 8'd1);
    wait_idle(50, "t2_idle");
    chk("t2_blank_cycles", cnt[7:0], 8'd0);
    chk("t2_pulses", pulses[7:0], 8'(p0 + 1));

    // 3: resolution change blanks through two settle frames
    res_req = 2'b01; k = 0;
    while (resolution_select !== 2'b01 && k < 100) begin @(negedge clk); k++; end
    chk("t3_res", {6'd0, resolution_select}, 8'h01);
    chk("t3_blank_at_apply", {7'd0, blank}, 8'd1);
    f0 = frame_starts; k = 0; cnt = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk); k++;
      if (busy === 1'b1 && blank !== 1'b1) cnt++;
    end
    chk("t3_settle_frames", 8'(frame_starts - f0), 8'd2);
    chk("t3_blank_low_early", cnt[7:0], 8'd0);
    chk("t3_blank_end", {7'd0, blank}, 8'd0);

    src_req = 3'b000;
    wait_idle(100, "t4_pre_idle");

    // 4: glitch shorter than the debounce window is discarded
    p0 = pulses;
    src_req = 3'b100;
    repeat (2) @(negedge clk);
    src_req = 3'b000;
    repeat (40) @(negedge clk);
    chk("t4_pulses", 8'(pulses - p0), 8'd0);
    chk("t4_out", {5'd0, output_select}, 8'd0);
    chk("t4_busy", {7'd0, busy}, 8'd0);

    // 5: new resolution request during SETTLE keeps video blanked to the end
    res_req = 2'b00;
    wait_idle(200, "t5_pre_idle");
    res_req = 2'b01; k = 0;
    while (resolution_select !== 2'b01 && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    res_req = 2'b10; k = 0; cnt = 0; p0 = pulses;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk); k++;
      if (busy === 1'b1 && blank !== 1'b1) cnt++;
    end
    chk("t5_res", {6'd0, resolution_select}, 8'h02);
    chk("t5_blank_low", cnt[7:0], 8'd0);
    chk("t5_pulses", 8'(pulses - p0), 8'd1);

    // 6: sync chain stalled
    vs_run = 1'b0;
    repeat (5) @(negedge clk);
    res_req = 2'b11; k = 0;
`ifdef MODE_SEQ_TIMEOUT_EN
    while (mode_applied !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("t6_timeout_latency", k[7:0], 8'd55);
    chk("t6_res", {6'd0, resolution_select}, 8'h03);
    wait_idle(200, "t6_settle_timeout");
`else
    repeat (150) @(negedge clk);
    chk("t6_stuck_busy", {7'd0, busy}, 8'd1);
    chk("t6_stuck_res", {6'd0, resolution_select}, 8'h02);
`endif
    vs_run = 1'b1;
    wait_idle(300, "t6_idle");
    chk("t6_final_res", {6'd0, resolution_select}, 8'h03);

    // randomized switch activity, glitches, long holds and occasional reset
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) res_req = 2'($urandom_range(0, 3));
        src_req = 3'($urandom_range(0, 7));
        repeat ((r < 60) ? $urandom_range(1, 5) : $urandom_range(20, 70)) @(negedge clk);
      end
    end
    res_req = 2'b00;
    src_req = 3'b000;
    wait_idle(400, "rand_final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
